line_write_buffer: RTL and testbench

// - Posted write buffer between the cache controller (upstream) and the line memory (downstream).
// - Absorbs dirty-line evictions in one short handshake so the cache is not stalled by slow memory.
// - Drains the buffered lines to memory in the background, in FIFO order.
// - Serves line reads that hit a buffered line directly; forwards read misses to memory.

---
 rtl/line_write_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_line_write_buffer.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_write_buffer.sv
// line_write_buffer: posted write buffer between the cache controller and line memory.
// Evicted lines are absorbed into a small FIFO in one short handshake, drained
// to memory in the background, and served directly to reads that hit them.
module line_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_read_addr,
  input  logic [31:0]       mem_write_addr,
  input  logic [LINE_W-1:0] mem_wr_data,
  output logic [LINE_W-1:0] mem_rd_data,
  output logic              mem_rd_data_valid,
  output logic              mem_wr_data_ready,
  output logic              dn_read,
  output logic              dn_write,
  output logic [31:0]       dn_rd_addr,
  output logic [31:0]       dn_wr_addr,
  output logic [LINE_W-1:0] dn_wr_data,
  input  logic [LINE_W-1:0] dn_rd_data,
  input  logic              dn_rd_data_valid,
  input  logic              dn_wr_data_ready,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    U_IDLE,
    U_WACK,
    U_RHIT,
    U_RMISS,
    U_RRESP
  } u_state_t;

  typedef enum logic {
    D_IDLE,
    D_WRITE
  } d_state_t;

  // Buffer storage
  logic [DEPTH-1:0]  r_valid;
  logic [27:0]       r_tag  [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  // Upstream read return path
  logic [LINE_W-1:0] r_rd_data;
  logic [27:0]       r_rd_tag;

  u_state_t r_u_state;
  u_state_t w_u_next;
  d_state_t r_d_state;
  d_state_t w_d_next;

  logic [27:0]   w_wtag;
  logic [27:0]   w_rtag;
  logic          w_wmatch;
  logic [AW-1:0] w_widx;
  logic          w_rmatch;
  logic [AW-1:0] w_ridx;
  logic          w_u_idle;
  logic          w_head_busy;
  logic          w_wblock;
  logic          w_coal_go;
  logic          w_alloc_go;
  logic          w_waccept;
  logic [AW-1:0] w_wr_slot;
  logic          w_rd_req;
  logic          w_rhit_go;
  logic          w_rmiss_go;
  logic          w_dn_read;
  logic          w_rresp_go;
  logic          w_drain_done;
  logic          w_unused_offset_bits;

  assign w_wtag = mem_write_addr[31:4];
  assign w_rtag = mem_read_addr[31:4];

  // Byte offsets within a line do not select anything; lines are moved whole.
  assign w_unused_offset_bits = ^{mem_read_addr[3:0], mem_write_addr[3:0]};

  // Tag lookup for the pending write and read requests; valid tags are unique
  always_comb begin
    w_wmatch = 1'b0;
    w_widx   = '0;
    w_rmatch = 1'b0;
    w_ridx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[AW'(i)] && (r_tag[AW'(i)] == w_wtag)) begin
        w_wmatch = 1'b1;
        w_widx   = AW'(i);
      end
      if (r_valid[AW'(i)] && (r_tag[AW'(i)] == w_rtag)) begin
        w_rmatch = 1'b1;
        w_ridx   = AW'(i);
      end
    end
  end

  assign w_u_idle    = (r_u_state == U_IDLE);
  assign w_head_busy = (r_d_state == D_WRITE);

  // The head being written downstream must not change under dn_wr_data, so a
  // write to that line waits for the drain to finish and then allocates anew.
  assign w_wblock   = w_wmatch && w_head_busy && (w_widx == r_head);
  assign w_coal_go  = w_u_idle && mem_write && w_wmatch && !w_wblock;
  assign w_alloc_go = w_u_idle && mem_write && !w_wmatch && (r_count < CW'(DEPTH));
  assign w_waccept  = w_coal_go || w_alloc_go;
  assign w_wr_slot  = w_alloc_go ? r_tail : w_widx;

  // A simultaneous write request is served first; the read waits behind it.
  assign w_rd_req   = w_u_idle && mem_read && !mem_write;
  assign w_rhit_go  = w_rd_req && w_rmatch;
  assign w_rmiss_go = w_rd_req && !w_rmatch;

  assign w_dn_read    = (r_u_state == U_RMISS) && (r_d_state == D_IDLE);
  assign w_rresp_go   = w_dn_read && dn_rd_data_valid;
  assign w_drain_done = w_head_busy && dn_wr_data_ready;

  // Upstream FSM next state and handshake outputs
  always_comb begin
    w_u_next          = r_u_state;
    mem_wr_data_ready = 1'b0;
    mem_rd_data_valid = 1'b0;
    dn_read           = 1'b0;
    case (r_u_state)
      U_IDLE: begin
        if (w_waccept) begin
          w_u_next = U_WACK;
        end else if (w_rhit_go) begin
          w_u_next = U_RHIT;
        end else if (w_rmiss_go) begin
          w_u_next = U_RMISS;
        end
      end
      U_WACK: begin
        mem_wr_data_ready = 1'b1;
        w_u_next          = U_IDLE;
      end
      U_RHIT: begin
        mem_rd_data_valid = 1'b1;
        w_u_next          = U_IDLE;
      end
      U_RMISS: begin
        dn_read = w_dn_read;
        if (w_rresp_go) begin
          w_u_next = U_RRESP;
        end
      end
      U_RRESP: begin
        mem_rd_data_valid = 1'b1;
        w_u_next          = U_IDLE;
      end
      default: w_u_next = U_IDLE;
    endcase
  end

  // Drain FSM next state; a pending or just-decided read miss blocks a new drain
  always_comb begin
    w_d_next = r_d_state;
    dn_write = 1'b0;
    case (r_d_state)
      D_IDLE: begin
        if ((r_count != '0) && (r_u_state != U_RMISS) && !w_rmiss_go) begin
          w_d_next = D_WRITE;
        end
      end
      D_WRITE: begin
        dn_write = 1'b1;
        if (dn_wr_data_ready) begin
          w_d_next = D_IDLE;
        end
      end
      default: w_d_next = D_IDLE;
    endcase
  end

  // State, occupancy and read-return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_u_state <= U_IDLE;
      r_d_state <= D_IDLE;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_rd_tag  <= '0;
    end else begin
      r_u_state <= w_u_next;
      r_d_state <= w_d_next;
      if (w_alloc_go) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + AW'(1);
      end
      // Allocation only happens below DEPTH, so tail never equals an in-flight head here.
      if (w_drain_done) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(w_alloc_go) - CW'(w_drain_done);
      if (w_rhit_go) begin
        r_rd_data <= r_data[w_ridx];
      end else if (w_rresp_go) begin
        r_rd_data <= dn_rd_data;
      end
      if (w_rmiss_go) begin
        r_rd_tag <= w_rtag;
      end
    end
  end

  // Entry payload: written on allocation or coalesce; validity lives in r_valid
  always_ff @(posedge clk) begin
    if (w_waccept) begin
      r_tag[w_wr_slot]  <= w_wtag;
      r_data[w_wr_slot] <= mem_wr_data;
    end
  end

  assign mem_rd_data = r_rd_data;
  assign dn_rd_addr  = {r_rd_tag, 4'b0000};
  assign dn_wr_addr  = dn_write ? {r_tag[r_head], 4'b0000} : '0;
  assign dn_wr_data  = dn_write ? r_data[r_head] : '0;
  assign empty       = (r_count == '0) && !dn_write && !dn_read;

endmodule

// File: tb/tb_line_write_buffer.sv
// tb_line_write_buffer: directed and randomized checks of line_write_buffer
// against a coherent-memory reference (latest written line wins).
module tb_line_write_buffer;

  localparam int unsigned LW = 128;
  localparam logic [LW-1:0] D1 = 128'hD1D1_0001_D1D1_0002_D1D1_0003_D1D1_0004;
  localparam logic [LW-1:0] D2 = 128'hD2D2_1111_D2D2_2222_D2D2_3333_D2D2_4444;
  localparam logic [LW-1:0] D3 = 128'hD3D3_AAAA_D3D3_BBBB_D3D3_CCCC_D3D3_DDDD;
  localparam logic [LW-1:0] D4 = 128'hD4D4_5555_D4D4_6666_D4D4_7777_D4D4_8888;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_read_addr;
  logic [31:0]   mem_write_addr;
  logic [LW-1:0] mem_wr_data;
  logic [LW-1:0] mem_rd_data;
  logic          mem_rd_data_valid;
  logic          mem_wr_data_ready;
  logic          dn_read;
  logic          dn_write;
  logic [31:0]   dn_rd_addr;
  logic [31:0]   dn_wr_addr;
  logic [LW-1:0] dn_wr_data;
  logic [LW-1:0] dn_rd_data;
  logic          dn_rd_data_valid;
  logic          dn_wr_data_ready;
  logic          empty;

  line_write_buffer #(.DEPTH(4), .LINE_W(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_addr     (mem_read_addr),
    .mem_write_addr    (mem_write_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_wr_data_ready (mem_wr_data_ready),
    .dn_read           (dn_read),
    .dn_write          (dn_write),
    .dn_rd_addr        (dn_rd_addr),
    .dn_wr_addr        (dn_wr_addr),
    .dn_wr_data        (dn_wr_data),
    .dn_rd_data        (dn_rd_data),
    .dn_rd_data_valid  (dn_rd_data_valid),
    .dn_wr_data_ready  (dn_wr_data_ready),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: latest value written upstream per line, and memory contents
  logic [LW-1:0] shadow    [logic [27:0]];
  logic [LW-1:0] mem_model [logic [31:0]];
  int            nwr       [logic [31:0]];
  logic [LW-1:0] exp_q     [$];

  // Downstream memory behaviour knobs
  int wr_lat   = 1;
  int rd_lat   = 2;
  bit wr_hold  = 1'b0;
  bit lat_rand = 1'b0;
  int wcnt     = 0;
  int rcnt     = 0;

  int   last_wack_cyc   = -1;
  int   last_rvalid_cyc = -1;
  int   dnrd_rise_cyc   = -1;
  int   dnrd_total      = 0;
  logic dn_read_prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [LW-1:0] init_mem(input logic [31:0] a);
    return {4{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_mem(a);
  endfunction

  function automatic logic [LW-1:0] expect_line(input logic [27:0] tag);
    if (shadow.exists(tag)) return shadow[tag];
    return mem_line({tag, 4'b0000});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream memory: acknowledges writes/reads after a programmable latency
  initial begin
    dn_wr_data_ready = 1'b0;
    dn_rd_data_valid = 1'b0;
    dn_rd_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      dn_wr_data_ready = 1'b0;
      dn_rd_data_valid = 1'b0;
      if (dn_write && !wr_hold) begin
        wcnt++;
        if (wcnt >= wr_lat) begin
          dn_wr_data_ready = 1'b1;
          wcnt = 0;
          chk("dn_wr_align", {124'b0, dn_wr_addr[3:0]}, '0);
          mem_model[dn_wr_addr] = dn_wr_data;
          if (nwr.exists(dn_wr_addr)) nwr[dn_wr_addr] = nwr[dn_wr_addr] + 1;
          else nwr[dn_wr_addr] = 1;
          if (lat_rand) wr_lat = $urandom_range(1, 6);
        end
      end else if (!dn_write) begin
        wcnt = 0;
      end
      if (dn_read) begin
        rcnt++;
        if (rcnt >= rd_lat) begin
          dn_rd_data_valid = 1'b1;
          dn_rd_data = mem_line(dn_rd_addr);
          rcnt = 0;
          chk("dn_rd_align", {124'b0, dn_rd_addr[3:0]}, '0);
          if (lat_rand) rd_lat = $urandom_range(1, 6);
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Scoreboard monitor: pops the expected line whenever a read completes
  always @(negedge clk) begin
    if (dn_wr_data_ready) last_wack_cyc = cyc;
    if (dn_rd_data_valid) last_rvalid_cyc = cyc;
    if (dn_read && !dn_read_prev) begin
      dnrd_rise_cyc = cyc;
      dnrd_total++;
    end
    dn_read_prev = dn_read;
    chk("dn_rd_wr_exclusive", {127'b0, dn_read & dn_write}, '0);
    if (mem_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected no response", mem_rd_data);
      end else begin
        chk("rd_data", mem_rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [LW-1:0] data, output int lat);
    int c0;
    bit got;
    c0 = cyc;
    got = 1'b0;
    lat = -1;
    mem_write_addr = addr;
    mem_wr_data = data;
    mem_write = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (mem_wr_data_ready) begin
        lat = cyc - c0;
        got = 1'b1;
        break;
      end
    end
    if (got) shadow[addr[31:4]] = data;
    else note_timeout("wr_ack");
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output int vcyc, output int lat);
    int c0;
    bit got;
    c0 = cyc;
    got = 1'b0;
    vcyc = -1;
    lat = -1;
    exp_q.push_back(expect_line(addr[31:4]));
    mem_read_addr = addr;
    mem_read = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (mem_rd_data_valid) begin
        vcyc = cyc;
        lat = cyc - c0;
        got = 1'b1;
        break;
      end
    end
    if (!got) note_timeout("rd_valid");
    tick();
    mem_read = 1'b0;
  endtask

  // Write and read raised together: the write must complete before the read
  task automatic do_both(input logic [31:0] waddr, input logic [LW-1:0] wdata, input logic [31:0] raddr);
    bit got;
    got = 1'b0;
    mem_write_addr = waddr;
    mem_wr_data = wdata;
    mem_read_addr = raddr;
    mem_write = 1'b1;
    mem_read = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      chk("both_no_early_rd", {127'b0, mem_rd_data_valid}, '0);
      if (mem_wr_data_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) shadow[waddr[31:4]] = wdata;
    else note_timeout("both_wr_ack");
    exp_q.push_back(expect_line(raddr[31:4]));
    tick();
    mem_write = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (mem_rd_data_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) note_timeout("both_rd_valid");
    tick();
    mem_read = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (empty && (exp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_timeout(name);
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shadow.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int vcyc;
    int kdn;
    int kack;
    int nbefore;
    int dbefore;
    bit seen;
    bit got;
    logic [LW-1:0] dtmp;

    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_read_addr = '0;
    mem_write_addr = '0;
    mem_wr_data = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_empty", {127'b0, empty}, 128'd1);
    chk("rst_dn_write", {127'b0, dn_write}, '0);
    chk("rst_dn_read", {127'b0, dn_read}, '0);
    chk("rst_rd_valid", {127'b0, mem_rd_data_valid}, '0);
    chk("rst_wr_ready", {127'b0, mem_wr_data_ready}, '0);
    chk("rst_rd_data", mem_rd_data, '0);
    tick();
    rst = 1'b0;

    // Single write, memory ready after 3 cycles
    wr_lat = 3;
    do_write(32'h100, D1, lat);
    chk("t1_ack_lat", lat, 128'd1);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dn_write) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) note_timeout("t1_dn_write");
    chk("t1_dn_addr", {96'b0, dn_wr_addr}, 128'h100);
    chk("t1_dn_data", dn_wr_data, D1);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dn_wr_data_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) note_timeout("t1_dn_ready");
    chk("t1_busy_at_ack", {127'b0, empty}, '0);
    @(negedge clk);
    chk("t1_empty_after", {127'b0, empty}, 128'd1);
    tick();
    chk("t1_mem", mem_line(32'h100), D1);

    // Full buffer: fifth line waits for the first drain completion
    wr_lat = 1;
    wr_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      dtmp = {$urandom, $urandom, $urandom, $urandom};
      do_write(32'(k * 32'h100), dtmp, lat);
      chk("t2_ack_lat", lat, 128'd1);
    end
    mem_write_addr = 32'h500;
    mem_wr_data = D3;
    mem_write = 1'b1;
    kdn = -1;
    kack = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 4) wr_hold = 1'b0;
      if (dn_wr_data_ready && (kdn < 0)) kdn = cyc;
      if (mem_wr_data_ready) begin
        kack = cyc;
        break;
      end
    end
    chk("t2_full_ack_cycle", kack, kdn + 2);
    shadow[28'h50] = D3;
    tick();
    mem_write = 1'b0;
    wait_idle("t2_drain");
    for (int k = 1; k <= 5; k++) begin
      chk("t2_mem", mem_line(32'(k * 32'h100)), shadow[28'(k * 16)]);
    end

    // Read hit while the drain is stalled on the head
    apply_reset();
    wr_hold = 1'b1;
    do_write(32'h100, D1, lat);
    do_write(32'h200, D2, lat);
    dbefore = dnrd_total;
    do_read(32'h208, vcyc, lat);
    chk("t3_hit_lat", lat, 128'd1);
    do_read(32'h104, vcyc, lat);
    chk("t3_head_hit_lat", lat, 128'd1);
    chk("t3_no_dn_read", dnrd_total, dbefore);

    // Coalescing into one buffered line
    apply_reset();
    wr_hold = 1'b1;
    do_write(32'h100, D1, lat);
    do_write(32'h300, D3, lat);
    do_write(32'h30C, D4, lat);
    chk("t4_coalesce_lat", lat, 128'd1);
    chk("t4_count", dut.r_count, 128'd2);
    nbefore = nwr.exists(32'h300) ? nwr[32'h300] : 0;
    @(negedge clk);
    wr_hold = 1'b0;
    tick();
    wait_idle("t4_drain");
    chk("t4_one_write", nwr.exists(32'h300) ? nwr[32'h300] - nbefore : 0, 128'd1);
    chk("t4_mem", mem_line(32'h300), D4);

    // Read miss behind an in-flight drain
    wr_hold = 1'b1;
    wr_lat = 1;
    rd_lat = 2;
    do_write(32'h700, D2, lat);
    @(negedge clk);
    chk("t5_dn_write", {127'b0, dn_write}, 128'd1);
    tick();
    last_wack_cyc = -1;
    last_rvalid_cyc = -1;
    dnrd_rise_cyc = -1;
    fork
      do_read(32'h600, vcyc, lat);
      begin
        seen = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (dn_read) seen = 1'b1;
        end
        chk("t5_no_early_dn_read", {127'b0, seen}, '0);
        wr_hold = 1'b0;
      end
    join
    chk("t5_dn_read_rise", dnrd_rise_cyc, last_wack_cyc + 1);
    chk("t5_rd_valid_cycle", vcyc, last_rvalid_cyc + 1);
    wait_idle("t5_drain");

    // Reset with lines buffered and a drain in flight
    wr_hold = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      dtmp = {$urandom, $urandom, $urandom, $urandom};
      do_write(32'(k * 32'h100), dtmp, lat);
    end
    @(negedge clk);
    chk("t6_dn_write_before", {127'b0, dn_write}, 128'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_dn_write_dropped", {127'b0, dn_write}, '0);
    chk("t6_empty", {127'b0, empty}, 128'd1);
    tick();
    rst = 1'b0;
    wr_hold = 1'b0;
    shadow.delete();
    dbefore = dnrd_total;
    do_read(32'h200, vcyc, lat);
    chk("t6_miss_to_mem", dnrd_total, dbefore + 1);
    wait_idle("t6_idle");

    // Randomized traffic over a small set of lines
    lat_rand = 1'b1;
    for (int it = 0; it < 250; it++) begin
      int op;
      logic [31:0] a;
      logic [31:0] b;
      op = $urandom_range(0, 9);
      a = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h10 + 32'($urandom_range(0, 15));
      b = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h10 + 32'($urandom_range(0, 15));
      dtmp = {$urandom, $urandom, $urandom, $urandom};
      if (op <= 4) begin
        do_write(a, dtmp, lat);
      end else if (op <= 8) begin
        do_read(a, vcyc, lat);
      end else begin
        do_both(a, dtmp, b);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand_drain");
    foreach (shadow[t]) begin
      chk("final_mem", mem_line({t, 4'b0000}), shadow[t]);
    end
    chk("sb_leftover", exp_q.size(), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
